// File: rtl/data_memory_bytewise_pkg.sv
// Shared definitions for the byte-addressed data memory.
// Covers RV32 load/store funct3 encodings and the controller state.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

endpackage

// File: rtl/data_memory_bytewise_lsu_align.sv
// Combinational lane logic: byte enables and shifted store data, load extraction/extension,
// plus alignment and funct3 legality.
module lsu_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] ldata,
  output logic        bad
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    case (lane)
      2'd0:    rbyte = rword[7:0];
      2'd1:    rbyte = rword[15:8];
      2'd2:    rbyte = rword[23:16];
      default: rbyte = rword[31:24];
    endcase
    rhalf = lane[1] ? rword[31:16] : rword[15:0];
  end

  always_comb begin
    be       = 4'b0000;
    wdata_sh = 32'd0;
    ldata    = 32'd0;
    bad      = 1'b0;
    case (funct3)
      F3_B, F3_BU: begin
        be       = 4'b0001 << lane;
        wdata_sh = {4{wdata[7:0]}};
        ldata    = (funct3 == F3_B) ? {{24{rbyte[7]}}, rbyte} : {24'd0, rbyte};
      end
      F3_H, F3_HU: begin
        bad      = lane[0];
        be       = lane[1] ? 4'b1100 : 4'b0011;
        wdata_sh = {2{wdata[15:0]}};
        ldata    = (funct3 == F3_H) ? {{16{rhalf[15]}}, rhalf} : {16'd0, rhalf};
      end
      F3_W: begin
        bad      = (lane != 2'd0);
        be       = 4'b1111;
        wdata_sh = wdata;
        ldata    = rword;
      end
      default: bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_memory_bytewise.sv
// RV32 byte-addressed data memory with valid/ready request port and registered response.
// After reset the array is cleared one word per cycle before requests are accepted.
module data_memory_bytewise
  import mem_pkg::*;
#(
  parameter int MEMORY_SIZE = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        busy
);

  localparam int DEPTH = MEMORY_SIZE / 4;
  localparam int IDX_W = $clog2(DEPTH);

  logic [31:0]      ram [DEPTH];
  state_t           state;
  logic [IDX_W-1:0] clear_idx;
  logic [IDX_W-1:0] idx;
  logic [31:0]      rword;
  logic [3:0]       be;
  logic [31:0]      wdata_sh;
  logic [31:0]      ldata;
  logic             align_bad;
  logic             range_bad;
  logic             err;
  logic             accept;

  assign idx       = req_addr[IDX_W+1:2];
  assign rword     = ram[idx];
  assign range_bad = (req_addr >= 32'(MEMORY_SIZE));
  // Unsigned funct3 encodings have no store counterpart.
  assign err       = align_bad | range_bad | (req_write & req_funct3[2]);
  assign accept    = req_valid & req_ready;

  lsu_align u_align (
    .funct3   (req_funct3),
    .lane     (req_addr[1:0]),
    .wdata    (req_wdata),
    .rword    (rword),
    .be       (be),
    .wdata_sh (wdata_sh),
    .ldata    (ldata),
    .bad      (align_bad)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= CLEAR;
      clear_idx <= '0;
      req_ready <= 1'b0;
      busy      <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_error <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clear_idx <= clear_idx + 1'b1;
          if (clear_idx == IDX_W'(DEPTH - 1)) begin
            state     <= READY;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: ;
      endcase
      rsp_valid <= accept;
      if (accept) begin
        rsp_error <= err;
        rsp_rdata <= (err || req_write) ? 32'd0 : ldata;
      end
    end
  end

  // Array has no reset; the clear sequence zeroes it instead.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      ram[clear_idx] <= 32'd0;
    end else if (!reset && accept && req_write && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) ram[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_bytewise.sv
// Directed self-checking bench for data_memory_bytewise (MEMORY_SIZE=64, 16-word clear).
module tb_data_memory_bytewise;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic        r_valid;
  logic [31:0] r_data;
  logic        r_err;

  data_memory_bytewise #(.MEMORY_SIZE(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_funct3 (req_funct3),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_error  (rsp_error),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Single request: present it, let one edge pass, sample the response 1ns later.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [2:0] f3,
                       input logic [31:0] wd);
    req_valid  = 1'b1;
    req_write  = wr;
    req_addr   = addr;
    req_funct3 = f3;
    req_wdata  = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    r_valid   = rsp_valid;
    r_data    = rsp_rdata;
    r_err     = rsp_error;
  endtask

  // Counts cycles spent not ready after a reset release, bounded.
  task automatic wait_clear(input string name);
    int n;
    n = 0;
    while (!req_ready && n < 100) begin
      total++;
      if (busy !== 1'b1) begin
        bad++;
        $display("FAIL %s busy during clear: got %b want 1", name, busy);
      end
      n++;
      @(posedge clk); #1;
    end
    total++;
    if (n !== 16) begin
      bad++;
      $display("FAIL %s clear cycles: got %0d want 16", name, n);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s busy after clear: got %b want 0", name, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({req_ready, rsp_valid, rsp_error, busy} !== 4'b0001 || rsp_rdata !== 32'd0) begin
      bad++;
      $display("FAIL reset_vals: got ready=%b vld=%b err=%b busy=%b rdata=%h want 0 0 0 1 0",
               req_ready, rsp_valid, rsp_error, busy, rsp_rdata);
    end
    reset = 1'b0;
    wait_clear("clear");
    issue(1'b0, 32'h3C, F3_W, 32'd0);
    total++;
    if (r_valid !== 1'b1 || r_data !== 32'd0 || r_err !== 1'b0) begin
      bad++;
      $display("FAIL clear_lw3c: got v=%b d=%h e=%b want 1 00000000 0", r_valid, r_data, r_err);
    end
    @(posedge clk); #1;
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL rsp_pulse: got %b want 0", rsp_valid);
    end
  endtask

  task automatic test_widths();
    logic [2:0]  f3s  [4] = '{F3_B, F3_BU, F3_H, F3_HU};
    logic [31:0] adrs [4] = '{32'h11, 32'h13, 32'h12, 32'h10};
    logic [31:0] exps [4] = '{32'hFFFFFFA2, 32'h00000080, 32'hFFFF8091, 32'h0000A2B3};
    issue(1'b1, 32'h10, F3_W, 32'h8091A2B3);
    total++;
    if (r_valid !== 1'b1 || r_data !== 32'd0 || r_err !== 1'b0) begin
      bad++;
      $display("FAIL sw_rsp: got v=%b d=%h e=%b want 1 00000000 0", r_valid, r_data, r_err);
    end
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, adrs[i], f3s[i], 32'd0);
      total++;
      if (r_data !== exps[i] || r_err !== 1'b0) begin
        bad++;
        $display("FAIL load_w%0d: got %h e=%b want %h e=0", i, r_data, r_err, exps[i]);
      end
    end
  endtask

  task automatic test_partial();
    issue(1'b1, 32'h20, F3_W, 32'hFFFFFFFF);
    issue(1'b1, 32'h21, F3_B, 32'h00000055);
    issue(1'b1, 32'h22, F3_H, 32'h00001234);
    issue(1'b0, 32'h20, F3_W, 32'd0);
    total++;
    if (r_data !== 32'h123455FF) begin
      bad++;
      $display("FAIL partial: got %h want 123455ff", r_data);
    end
  endtask

  task automatic test_errors();
    logic        wrs  [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] adrs [7] = '{32'h32, 32'h31, 32'h1000, 32'h40, 32'h30, 32'h30, 32'h32};
    logic [2:0]  f3s  [7] = '{F3_W, F3_H, F3_W, F3_W, F3_BU, 3'b011, F3_W};
    issue(1'b1, 32'h30, F3_W, 32'hDEADBEEF);
    for (int i = 0; i < 7; i++) begin
      issue(wrs[i], adrs[i], f3s[i], 32'h0BADF00D);
      total++;
      if (r_valid !== 1'b1 || r_err !== 1'b1 || r_data !== 32'd0) begin
        bad++;
        $display("FAIL err%0d: got v=%b e=%b d=%h want 1 1 00000000", i, r_valid, r_err, r_data);
      end
    end
    issue(1'b0, 32'h3F, F3_B, 32'd0);
    total++;
    if (r_err !== 1'b0 || r_data !== 32'd0) begin
      bad++;
      $display("FAIL edge_lb3f: got e=%b d=%h want 0 00000000", r_err, r_data);
    end
    issue(1'b0, 32'h30, F3_W, 32'd0);
    total++;
    if (r_data !== 32'hDEADBEEF || r_err !== 1'b0) begin
      bad++;
      $display("FAIL err_unchanged: got %h e=%b want deadbeef e=0", r_data, r_err);
    end
  endtask

  task automatic test_back_to_back();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h08;
    req_funct3 = F3_W; req_wdata = 32'hCAFEBABE;
    @(posedge clk); #1;
    total++;
    if (rsp_valid !== 1'b1 || rsp_error !== 1'b0) begin
      bad++;
      $display("FAIL b2b_first: got v=%b e=%b want 1 0", rsp_valid, rsp_error);
    end
    req_write = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    total++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFEBABE) begin
      bad++;
      $display("FAIL b2b_second: got v=%b d=%h want 1 cafebabe", rsp_valid, rsp_rdata);
    end
    @(posedge clk); #1;
    total++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'hCAFEBABE) begin
      bad++;
      $display("FAIL rsp_hold: got v=%b d=%h want 0 cafebabe", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h08;
    req_funct3 = F3_W; req_wdata = 32'd0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset     = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    total++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== 32'd0) begin
      bad++;
      $display("FAIL mid_reset: got v=%b busy=%b ready=%b d=%h want 0 1 0 00000000",
               rsp_valid, busy, req_ready, rsp_rdata);
    end
    wait_clear("reclear");
    issue(1'b0, 32'h08, F3_W, 32'd0);
    total++;
    if (r_data !== 32'd0 || r_err !== 1'b0) begin
      bad++;
      $display("FAIL reclear_08: got %h e=%b want 00000000 e=0", r_data, r_err);
    end
    issue(1'b0, 32'h30, F3_W, 32'd0);
    total++;
    if (r_data !== 32'd0) begin
      bad++;
      $display("FAIL reclear_30: got %h want 00000000", r_data);
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_addr = 32'd0; req_funct3 = 3'd0; req_wdata = 32'd0;
    r_valid = 1'b0; r_data = 32'd0; r_err = 1'b0;
    test_reset();
    test_widths();
    test_partial();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_memory_bytewise.md
Name: data_memory_bytewise

Overview:
Byte-addressed RV32 data memory with a valid/ready request port and a registered one-cycle response. Supports LB/LH/LW/LBU/LHU and SB/SH/SW through byte-lane enables and load sign/zero extension. Flags misaligned, out-of-range and illegal-funct3 accesses as errors. Clears its array one word per cycle after reset. Sits between the core's MEM stage and the word array, and replaces the word-indexed, single-cycle-reset data memory.

Parameters:
MEMORY_SIZE, 4096, array size in bytes; power of two, at least 8.
DEPTH, MEMORY_SIZE/4, word count (localparam).
IDX_W, $clog2(DEPTH), word index width (localparam).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block accepts a request this cycle
req_write  in  1  1 = store, 0 = load
req_addr  in  32  byte address
req_funct3  in  3  RV32 load/store funct3
req_wdata  in  32  store data, right-aligned
rsp_valid  out  1  response valid; one-cycle pulse
rsp_rdata  out  32  load result, extended; 0 for stores and errors
rsp_error  out  1  the accepted request was illegal
busy  out  1  clear sequence in progress

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, busy=1, state=CLEAR, clear_idx=0.
- Reset is sampled on every posedge; any in-flight response is dropped.
- Asserting reset mid-operation restarts the clear sequence at index 0.
- FSM has two states: CLEAR and READY.
- CLEAR:
  - Writes 0 to ram[clear_idx] each cycle and increments clear_idx.
  - Moves to READY on the cycle that writes index DEPTH-1.
  - Clearing takes exactly DEPTH cycles after reset deasserts.
  - req_ready=0 and busy=1 throughout.
- READY:
  - req_ready=1 and busy=0.
  - Accept occurs when req_valid && req_ready.
  - Full throughput: one request per cycle, back-to-back.
- Response timing:
  - On the edge after an accept: rsp_valid=1 with rsp_rdata and rsp_error.
  - With no accept, rsp_valid returns to 0 on the next edge.
  - rsp_rdata and rsp_error hold their values until the next response.
- Word index: req_addr[IDX_W+1:2]. Lane: req_addr[1:0].
- Error conditions (any one sets rsp_error=1, rsp_rdata=0, no array write):
  - req_addr >= MEMORY_SIZE.
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - funct3 in {011, 110, 111}.
  - Store with funct3 100 or 101.
- Stores:
  - Written at the accepting edge.
  - SB (000) writes lane addr[1:0] with wdata[7:0].
  - SH (001) writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - SW (010) writes all four lanes.
  - Unselected lanes are unchanged.
- Loads:
  - The word is read at the accepting edge; lane extraction is combinational ahead of the response register.
  - LB sign-extends, LBU zero-extends; LH/LHU likewise; LW passes the word through.
- Read-after-write: a load accepted in the cycle after a store to the same word returns the updated data. No bypass is needed because the write lands before the read edge.
- Addresses never wrap; addresses at or beyond MEMORY_SIZE always raise an error.

Decomposition:
- Package mem_pkg holds:
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - State enum {CLEAR, READY}.
- Sub-module lsu_align (purely combinational) takes funct3, addr[1:0], wdata and the read word. It produces:
  - 4-bit byte enable.
  - Lane-shifted write data.
  - Extended load data.
  - misaligned/illegal flag.
- Top level keeps the FSM, clear counter, array, range check and response register.

Test Plan:
- Clear sequence: pulse reset 1 cycle, MEMORY_SIZE=64 -> busy=1 and req_ready=0 for exactly 16 cycles, then req_ready=1; LW 0x3C returns 0.
- Store/load widths: SW 0x10 data 0x8091A2B3, then:
  - LB 0x11 -> 0xFFFFFFA2
  - LBU 0x13 -> 0x00000080
  - LH 0x12 -> 0xFFFF8091
  - LHU 0x10 -> 0x0000A2B3
- Partial stores: SW 0x20 0xFFFFFFFF, SB 0x21 0x00000055, SH 0x22 0x00001234 -> LW 0x20 = 0x123455FF.
- Errors, all with rsp_error=1 and memory unchanged (checked by LW 0x30 = 0xDEADBEEF):
  - LW 0x32
  - LH 0x31
  - SW 0x1000 (size 4096)
  - store with funct3=100
  - load with funct3=011
- Back-to-back: SW 0x08 0xCAFEBABE then LW 0x08 on consecutive cycles -> two rsp_valid pulses on consecutive cycles; second rsp_rdata=0xCAFEBABE.
- Reset mid-stream: LW accepted, reset asserted the next cycle -> rsp_valid=0 after that edge, busy=1, full clear repeats, and previously stored data reads back 0.
